// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory signal bundle for mem_arbiter
//
// Purpose: groups the fetch port, data port and single-port memory port of the
// arbiter so they travel as one interface.
// Modports:
//   slave  - the arbiter's view (takes requests and memory responses, drives
//            acks, read data and memory commands)
//   master - the environment's view (drives requests and memory responses)
// Signals:
//   if_req/if_addr/if_rdata/if_ack                 fetch read port
//   d_req/d_we/d_width/d_addr/d_wdata/
//   d_rdata/d_ack/d_err                            data load/store port
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata/
//   mem_rdata/mem_ready                            single-port memory

interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_width;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  d_req, d_we, d_width, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output d_req, d_we, d_width, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port memory
//
// Purpose: shares one memory port between an instruction fetch requester and a
// load/store requester. Data normally wins; a waiting fetch is forced through
// after STARVE_LIMIT consecutive data grants. Misaligned or invalid-width data
// accesses are rejected without touching memory. Loads are lane-shifted and
// sign/zero-extended, stores get byte strobes and lane-replicated data.
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - mem_arbiter_if.slave (fetch port, data port, memory port)
// All outputs come straight from flops.

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [2:0]       width_q, width_d;
  logic [1:0]       off_q, off_d;
  logic             if_ack_q, if_ack_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic             d_ack_q, d_ack_d;
  logic             d_err_q, d_err_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             d_bad;
  logic             starved;

  // Store strobes: width code bits [1:0] select B/H/W; BU/HU stores behave as B/H.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b1111;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    r = wd;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    r = '0;
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'h0, s[7:0]};
      F3_HU:   r = {16'h0, s[15:0]};
      F3_W:    r = s;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Rejection rule: unknown width codes, odd halfwords, non-word-aligned words.
  always_comb begin
    d_bad = 1'b0;
    case (bus.d_width)
      F3_B, F3_BU: d_bad = 1'b0;
      F3_H, F3_HU: d_bad = bus.d_addr[0];
      F3_W:        d_bad = |bus.d_addr[1:0];
      default:     d_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    width_d      = width_q;
    off_d        = off_q;
    if_ack_d     = 1'b0;
    if_rdata_d   = '0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = '0;
    starved      = bus.if_req && (starve_cnt_q == LIMIT);

    case (state_q)
      IDLE: begin
        if (bus.d_req && !starved) begin
          // A rejected access still uses the arbitration slot, so it counts
          // against a waiting fetch just like a real data grant.
          if (!bus.if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
          if (d_bad) begin
            state_d = DONE;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            state_d     = GRANT_D;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = {bus.d_addr[31:2], 2'b00};
            mem_wstrb_d = bus.d_we ? store_strb(bus.d_width, bus.d_addr[1:0]) : 4'b0000;
            mem_wdata_d = bus.d_we ? store_data(bus.d_width, bus.d_wdata) : 32'h0;
            width_d     = bus.d_width;
            off_d       = bus.d_addr[1:0];
          end
        end else if (bus.if_req) begin
          state_d      = GRANT_I;
          starve_cnt_d = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {bus.if_addr[31:2], 2'b00};
          mem_wstrb_d  = 4'b0000;
          mem_wdata_d  = 32'h0;
        end else begin
          starve_cnt_d = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        // mem_req_q is always set here; the qualifier keeps a stray mem_ready
        // from ever being taken as a completion.
        if (bus.mem_ready && mem_req_q) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
          if (state_q == GRANT_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_we_q ? 32'h0 : load_align(bus.mem_rdata, width_q, off_q);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      width_q      <= 3'b000;
      off_q        <= 2'b00;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      width_q      <= width_d;
      off_q        <= off_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter

module tb_mem_arbiter;

  logic clk;
  logic reset;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } ack_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_t;

  ack_t ack_q[$];
  mem_t mem_q[$];
  ack_t cur_a;
  mem_t cur_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int mem_lat  = 0;
  bit mem_hold = 1'b0;
  int wait_cnt;
  bit mem_req_seen;
  int lat_f, lat_d;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'h1234_5678;
    if (a == 32'h0000_0200) return 32'h80FF_FFFF;
    return {a[15:0] ^ 16'hC35A, a[15:0]};
  endfunction

  assign bus.mem_rdata = rd_model(bus.mem_addr);
  assign bus.mem_ready = bus.mem_req && !mem_hold && (wait_cnt >= mem_lat);

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else        wait_cnt <= (bus.mem_req && !bus.mem_ready) ? wait_cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input bit we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd);
    mem_t m;
    m.we = we; m.addr = a; m.wstrb = s; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  task automatic exp_ack(input bit is_d, input logic [31:0] rd, input bit err);
    ack_t a;
    a.is_d = is_d; a.rdata = rd; a.err = err;
    ack_q.push_back(a);
  endtask

  // Scoreboard: memory commands are compared every cycle they are presented
  // (so they must stay stable), acks are popped in expected grant order.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_req) begin
        mem_req_seen = 1'b1;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", 32'(bus.mem_req), 32'd0);
        end else begin
          cur_m = mem_q[0];
          chk("mem_we", 32'(bus.mem_we), 32'(cur_m.we));
          chk("mem_addr", bus.mem_addr, cur_m.addr);
          chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur_m.wstrb));
          chk("mem_wdata", bus.mem_wdata, cur_m.wdata);
          if (bus.mem_ready) void'(mem_q.pop_front());
        end
      end
      if (bus.if_ack || bus.d_ack) begin
        chk("ack_overlap", 32'(bus.if_ack & bus.d_ack), 32'd0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          cur_a = ack_q.pop_front();
          chk("ack_port_is_data", 32'(bus.d_ack), 32'(cur_a.is_d));
          if (cur_a.is_d) begin
            chk("d_rdata", bus.d_rdata, cur_a.rdata);
            chk("d_err", 32'(bus.d_err), 32'(cur_a.err));
          end else begin
            chk("if_rdata", bus.if_rdata, cur_a.rdata);
          end
        end
      end
    end
  end

  task automatic fetch_req(input logic [31:0] a, output int lat);
    int n;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.if_ack && n < 40);
    chk("if_ack_timeout", 32'(bus.if_ack), 32'd1);
    lat = n - 1;
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input bit keep, output int lat);
    int n;
    bus.d_we    = we;
    bus.d_width = w;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_ack && n < 40);
    chk("d_ack_timeout", 32'(bus.d_ack), 32'd1);
    lat = n - 1;
    if (!keep) begin
      @(posedge clk);
      #1;
      bus.d_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary by 100us, expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_width = 3'b000;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    mem_req_seen = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
    chk("rst_d_err", 32'(bus.d_err), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch, zero-latency memory
    exp_mem(1'b0, 32'h0000_1004, 4'b0000, 32'h0);
    exp_ack(1'b0, 32'h1234_5678, 1'b0);
    fetch_req(32'h0000_1006, lat_f);
    chk("fetch_latency", 32'(lat_f), 32'd2);

    // Simultaneous requests: data first, fetch three cycles later
    exp_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    exp_mem(1'b0, 32'h0000_2000, 4'b0000, 32'h0);
    exp_ack(1'b1, rd_model(32'h0000_0100), 1'b0);
    exp_ack(1'b0, rd_model(32'h0000_2000), 1'b0);
    fork
      data_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0, lat_d);
      fetch_req(32'h0000_2000, lat_f);
    join
    chk("data_first_latency", 32'(lat_d), 32'd2);
    chk("fetch_after_data_latency", 32'(lat_f), 32'd5);

    // Load extension and store lanes
    exp_mem(1'b0, 32'h200, 4'b0000, 32'h0); exp_ack(1'b1, 32'hFFFF_FF80, 1'b0);
    data_req(1'b0, 3'b000, 32'h203, 32'h0, 1'b0, lat_d);
    exp_mem(1'b0, 32'h200, 4'b0000, 32'h0); exp_ack(1'b1, 32'h0000_80FF, 1'b0);
    data_req(1'b0, 3'b101, 32'h202, 32'h0, 1'b0, lat_d);
    exp_mem(1'b0, 32'h200, 4'b0000, 32'h0); exp_ack(1'b1, 32'hFFFF_FFFF, 1'b0);
    data_req(1'b0, 3'b001, 32'h200, 32'h0, 1'b0, lat_d);
    exp_mem(1'b0, 32'h200, 4'b0000, 32'h0); exp_ack(1'b1, 32'h0000_00FF, 1'b0);
    data_req(1'b0, 3'b100, 32'h201, 32'h0, 1'b0, lat_d);
    mem_lat = 2;
    exp_mem(1'b1, 32'h200, 4'b0010, 32'hABAB_ABAB); exp_ack(1'b1, 32'h0, 1'b0);
    data_req(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 1'b0, lat_d);
    exp_mem(1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF); exp_ack(1'b1, 32'h0, 1'b0);
    data_req(1'b1, 3'b001, 32'h202, 32'h1234_BEEF, 1'b0, lat_d);
    exp_mem(1'b1, 32'h300, 4'b1111, 32'hDEAD_BEEF); exp_ack(1'b1, 32'h0, 1'b0);
    data_req(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 1'b0, lat_d);
    chk("store_lat2_latency", 32'(lat_d), 32'd4);
    mem_lat = 3;
    exp_mem(1'b0, 32'h204, 4'b0000, 32'h0); exp_ack(1'b1, rd_model(32'h204), 1'b0);
    data_req(1'b0, 3'b010, 32'h204, 32'h0, 1'b0, lat_d);
    mem_lat = 0;

    // Rejected accesses never reach memory
    mem_req_seen = 1'b0;
    exp_ack(1'b1, 32'h0, 1'b1);
    data_req(1'b1, 3'b010, 32'h102, 32'h5555_5555, 1'b0, lat_d);
    chk("reject_latency", 32'(lat_d), 32'd1);
    exp_ack(1'b1, 32'h0, 1'b1);
    data_req(1'b0, 3'b001, 32'h201, 32'h0, 1'b0, lat_d);
    exp_ack(1'b1, 32'h0, 1'b1);
    data_req(1'b0, 3'b011, 32'h200, 32'h0, 1'b0, lat_d);
    exp_ack(1'b1, 32'h0, 1'b1);
    data_req(1'b0, 3'b111, 32'h200, 32'h0, 1'b0, lat_d);
    exp_ack(1'b1, 32'h0, 1'b1);
    data_req(1'b0, 3'b010, 32'h101, 32'h0, 1'b0, lat_d);
    chk("reject_no_mem_req", 32'(mem_req_seen), 32'd0);

    // Starvation: four data grants, then the waiting fetch, then data again
    for (int i = 0; i < 4; i++) begin
      exp_mem(1'b0, 32'h400 + 32'(4 * i), 4'b0000, 32'h0);
      exp_ack(1'b1, rd_model(32'h400 + 32'(4 * i)), 1'b0);
    end
    exp_mem(1'b0, 32'h3000, 4'b0000, 32'h0);
    exp_ack(1'b0, rd_model(32'h3000), 1'b0);
    exp_mem(1'b0, 32'h410, 4'b0000, 32'h0);
    exp_ack(1'b1, rd_model(32'h410), 1'b0);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          data_req(1'b0, 3'b010, 32'h400 + 32'(4 * i), 32'h0, (i < 4), lat_d);
        end
      end
      fetch_req(32'h3000, lat_f);
    join
    chk("starved_fetch_latency", 32'(lat_f), 32'd14);

    // Reset in the middle of a data grant with memory stalled
    mem_hold = 1'b1;
    exp_mem(1'b0, 32'h500, 4'b0000, 32'h0);
    bus.d_we    = 1'b0;
    bus.d_width = 3'b010;
    bus.d_addr  = 32'h500;
    bus.d_req   = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_mem_req_high", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_d_ack", 32'(bus.d_ack), 32'd0);
    chk("async_rst_if_ack", 32'(bus.if_ack), 32'd0);
    chk("async_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("abandoned_no_ack_pending", 32'(ack_q.size()), 32'd0);
    mem_q.delete();
    bus.d_req = 1'b0;
    mem_hold  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_mem(1'b0, 32'h0000_1004, 4'b0000, 32'h0);
    exp_ack(1'b0, 32'h1234_5678, 1'b0);
    fetch_req(32'h0000_1006, lat_f);
    chk("post_reset_fetch_latency", 32'(lat_f), 32'd2);

    repeat (3) @(negedge clk);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
